// File: rtl/mem_port_arbiter_if.sv
// Memory-port bundle: request, write-data and response channels of one port.
// The requester side uses master; the side that owns the memory uses slave.
interface mem_port_arbiter_if #(
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128,
    parameter int TAG_BITS  = 4
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_rw;
    logic [ADDR_BITS-1:0]   req_addr;
    logic [TAG_BITS-1:0]    req_tag;
    logic                   req_data_valid;
    logic                   req_data_ready;
    logic [DATA_BITS-1:0]   req_data_bits;
    logic [DATA_BITS/8-1:0] req_data_mask;
    logic                   resp_valid;
    logic [TAG_BITS-1:0]    resp_tag;
    logic [DATA_BITS-1:0]   resp_data;

    modport master (
        output req_valid, req_rw, req_addr, req_tag,
        output req_data_valid, req_data_bits, req_data_mask,
        input  req_ready, req_data_ready,
        input  resp_valid, resp_tag, resp_data
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_tag,
        input  req_data_valid, req_data_bits, req_data_mask,
        output req_ready, req_data_ready,
        output resp_valid, resp_tag, resp_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one external memory port between icache (port 0)
// and dcache (port 1); writes lock the data channel for a full line.
module mem_port_arbiter #(
    parameter int MEM_ADDR_BITS = 28,
    parameter int MEM_DATA_BITS = 128,
    parameter int MEM_TAG_BITS  = 5,
    parameter int DATA_BEATS    = 4
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.slave  ic,
    mem_port_arbiter_if.slave  dc,
    mem_port_arbiter_if.master mem
);
    localparam int PORT_TAG_BITS = MEM_TAG_BITS - 1;
    localparam int MASK_BITS     = MEM_DATA_BITS / 8;
    localparam int BEAT_BITS     = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(DATA_BEATS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] WDATA = 2'd2;

    logic [1:0]           state_reg, state_next;
    logic                 owner_reg, owner_next;
    logic                 rr_last_reg, rr_last_next;
    logic [BEAT_BITS-1:0] beat_cnt_reg, beat_cnt_next;

    logic [1:0]               port_req_valid;
    logic [1:0]               port_req_rw;
    logic [1:0]               port_data_valid;
    logic [MEM_ADDR_BITS-1:0] port_req_addr [2];
    logic [PORT_TAG_BITS-1:0] port_req_tag [2];
    logic [MEM_DATA_BITS-1:0] port_data_bits [2];
    logic [MASK_BITS-1:0]     port_data_mask [2];
    logic [1:0]               port_req_ready;
    logic [1:0]               port_data_ready;
    logic [1:0]               port_resp_valid;

    logic grant_id;
    logic grant_valid;
    logic req_fire;
    logic data_fire;
    logic in_wdata;

    assign port_req_valid    = {dc.req_valid, ic.req_valid};
    assign port_req_rw       = {dc.req_rw, ic.req_rw};
    assign port_data_valid   = {dc.req_data_valid, ic.req_data_valid};
    assign port_req_addr[0]  = ic.req_addr;
    assign port_req_addr[1]  = dc.req_addr;
    assign port_req_tag[0]   = ic.req_tag;
    assign port_req_tag[1]   = dc.req_tag;
    assign port_data_bits[0] = ic.req_data_bits;
    assign port_data_bits[1] = dc.req_data_bits;
    assign port_data_mask[0] = ic.req_data_mask;
    assign port_data_mask[1] = dc.req_data_mask;

    // In HOLD the grant is frozen on the owner until its handshake completes.
    always_comb begin
        grant_id    = owner_reg;
        grant_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                grant_valid = |port_req_valid;
                grant_id    = (&port_req_valid) ? ~rr_last_reg : port_req_valid[1];
            end
            HOLD: begin
                grant_valid = port_req_valid[owner_reg];
            end
            default: ;
        endcase
    end

    assign in_wdata  = reset && (state_reg == WDATA);
    assign req_fire  = reset && grant_valid && mem.req_ready;
    assign data_fire = in_wdata && port_data_valid[owner_reg] && mem.req_data_ready;

    assign mem.req_valid      = reset && grant_valid;
    assign mem.req_rw         = port_req_rw[grant_id];
    assign mem.req_addr       = port_req_addr[grant_id];
    assign mem.req_tag        = {grant_id, port_req_tag[grant_id]};
    assign mem.req_data_valid = in_wdata && port_data_valid[owner_reg];
    assign mem.req_data_bits  = port_data_bits[owner_reg];
    assign mem.req_data_mask  = port_data_mask[owner_reg];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign port_req_ready[gi]  = req_fire && (grant_id == 1'(gi));
            assign port_data_ready[gi] = in_wdata && (owner_reg == 1'(gi)) && mem.req_data_ready;
            assign port_resp_valid[gi] = reset && mem.resp_valid &&
                                         (mem.resp_tag[MEM_TAG_BITS-1] == 1'(gi));
        end
    endgenerate

    assign ic.req_ready      = port_req_ready[0];
    assign dc.req_ready      = port_req_ready[1];
    assign ic.req_data_ready = port_data_ready[0];
    assign dc.req_data_ready = port_data_ready[1];
    assign ic.resp_valid     = port_resp_valid[0];
    assign dc.resp_valid     = port_resp_valid[1];
    assign ic.resp_tag       = mem.resp_tag[PORT_TAG_BITS-1:0];
    assign dc.resp_tag       = mem.resp_tag[PORT_TAG_BITS-1:0];
    assign ic.resp_data      = mem.resp_data;
    assign dc.resp_data      = mem.resp_data;

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        rr_last_next  = rr_last_reg;
        beat_cnt_next = beat_cnt_reg;
        case (state_reg)
            IDLE, HOLD: begin
                if (grant_valid) begin
                    owner_next = grant_id;
                    if (req_fire) begin
                        rr_last_next  = grant_id;
                        beat_cnt_next = '0;
                        state_next    = port_req_rw[grant_id] ? WDATA : IDLE;
                    end else begin
                        state_next = HOLD;
                    end
                end
            end
            WDATA: begin
                if (data_fire) begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                    if (beat_cnt_reg == LAST_BEAT) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            owner_reg    <= 1'b0;
            rr_last_reg  <= 1'b1;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            rr_last_reg  <= rr_last_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench: a transaction-level model predicts every memory-side
// handshake and response route; a monitor pops and compares as the DUT shows them.
module tb_mem_port_arbiter;
    localparam int AW   = 28;
    localparam int DW   = 128;
    localparam int TW   = 5;
    localparam int NB   = 4;
    localparam int MW   = DW / 8;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_BITS(AW), .DATA_BITS(DW), .TAG_BITS(TW-1)) ic_bus();
    mem_port_arbiter_if #(.ADDR_BITS(AW), .DATA_BITS(DW), .TAG_BITS(TW-1)) dc_bus();
    mem_port_arbiter_if #(.ADDR_BITS(AW), .DATA_BITS(DW), .TAG_BITS(TW))   mem_bus();

    mem_port_arbiter #(
        .MEM_ADDR_BITS(AW), .MEM_DATA_BITS(DW), .MEM_TAG_BITS(TW), .DATA_BEATS(NB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ic(ic_bus),
        .dc(dc_bus),
        .mem(mem_bus)
    );

    typedef struct packed {
        logic                   rw;
        logic [AW-1:0]          addr;
        logic [TW-2:0]          tag;
        logic [NB-1:0][DW-1:0]  data;
        logic [NB-1:0][MW-1:0]  mask;
    } txn_t;

    typedef struct packed { logic port; logic rw; logic [AW-1:0] addr; logic [TW-1:0] tag; } req_exp_t;
    typedef struct packed { logic port; logic [DW-1:0] bits; logic [MW-1:0] mask; } dat_exp_t;
    typedef struct packed { logic port; logic [TW-2:0] tag; logic [DW-1:0] data; } rsp_exp_t;

    req_exp_t req_q[$];
    dat_exp_t dat_q[$];
    rsp_exp_t rsp_q[$];

    int checks = 0;
    int errors = 0;

    function automatic logic [DW-1:0] rand_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic txn_t gen_txn();
        txn_t t;
        t.rw   = 1'($urandom_range(0, 1));
        t.addr = AW'($urandom);
        t.tag  = (TW-1)'($urandom);
        for (int b = 0; b < NB; b++) begin
            t.data[b] = rand_beat();
            t.mask[b] = MW'($urandom);
        end
        return t;
    endfunction

    task automatic set_port(input int p, input logic v, input txn_t t, input logic dv,
                            input logic [DW-1:0] bits, input logic [MW-1:0] mask);
        if (p == 0) begin
            ic_bus.req_valid      = v;
            ic_bus.req_rw         = t.rw;
            ic_bus.req_addr       = t.addr;
            ic_bus.req_tag        = t.tag;
            ic_bus.req_data_valid = dv;
            ic_bus.req_data_bits  = bits;
            ic_bus.req_data_mask  = mask;
        end else begin
            dc_bus.req_valid      = v;
            dc_bus.req_rw         = t.rw;
            dc_bus.req_addr       = t.addr;
            dc_bus.req_tag        = t.tag;
            dc_bus.req_data_valid = dv;
            dc_bus.req_data_bits  = bits;
            dc_bus.req_data_mask  = mask;
        end
    endtask

    // Stimulus plus reference model: requesters hold a pending transaction until
    // the model says it was accepted; the shared port is free, held or line-locked.
    initial begin : driver
        txn_t       cur [2];
        bit         has_txn [2];
        bit         in_data [2];
        int         writer;
        int         beats;
        int         held;
        logic       rr_last;
        int         w;
        int         n_mid_rst;
        logic [1:0] rv;
        logic [1:0] dv;
        logic       mrdy;
        logic       drdy;
        logic [DW-1:0] bits;
        logic [MW-1:0] mask;
        req_exp_t   er;
        dat_exp_t   ed;
        rsp_exp_t   es;

        writer = -1; beats = 0; held = -1; rr_last = 1'b1; n_mid_rst = 0;
        for (int p = 0; p < 2; p++) begin
            has_txn[p] = 1'b0;
            in_data[p] = 1'b0;
            cur[p] = gen_txn();
            set_port(p, 1'b0, cur[p], 1'b0, '0, '0);
        end
        mem_bus.req_ready = 1'b0; mem_bus.req_data_ready = 1'b0;
        mem_bus.resp_valid = 1'b0; mem_bus.resp_tag = '0; mem_bus.resp_data = '0;

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            if (c < 3 || (c % 613 == 0) ||
                (c > 100 && n_mid_rst < 3 && writer >= 0 && beats == 2)) begin
                if (c >= 3 && writer >= 0) n_mid_rst++;
                reset = 1'b0;
            end else begin
                reset = 1'b1;
            end

            if (c == 3) begin
                for (int p = 0; p < 2; p++) begin
                    cur[p] = gen_txn();
                    cur[p].rw = 1'b0;
                    has_txn[p] = 1'b1;
                    in_data[p] = 1'b0;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (!has_txn[p] && $urandom_range(0, 99) < 40) begin
                    cur[p] = gen_txn();
                    has_txn[p] = 1'b1;
                    in_data[p] = 1'b0;
                end
            end
            for (int p = 0; p < 2; p++) begin
                rv[p] = has_txn[p] && !in_data[p];
                dv[p] = in_data[p] && ($urandom_range(0, 99) < 70);
                bits  = in_data[p] ? cur[p].data[beats] : rand_beat();
                mask  = in_data[p] ? cur[p].mask[beats] : MW'($urandom);
                set_port(p, rv[p], cur[p], dv[p], bits, mask);
            end
            mrdy = (c == 3 || c == 4) ? 1'b1 : ($urandom_range(0, 99) < 60);
            drdy = $urandom_range(0, 99) < 60;
            mem_bus.req_ready      = mrdy;
            mem_bus.req_data_ready = drdy;
            mem_bus.resp_valid     = $urandom_range(0, 99) < 30;
            mem_bus.resp_tag       = TW'($urandom);
            mem_bus.resp_data      = rand_beat();

            if (!reset) begin
                writer = -1; beats = 0; held = -1; rr_last = 1'b1;
                for (int p = 0; p < 2; p++) begin
                    if (in_data[p]) begin
                        has_txn[p] = 1'b0;
                        in_data[p] = 1'b0;
                    end
                end
            end else begin
                if (mem_bus.resp_valid) begin
                    es.port = mem_bus.resp_tag[TW-1];
                    es.tag  = mem_bus.resp_tag[TW-2:0];
                    es.data = mem_bus.resp_data;
                    rsp_q.push_back(es);
                end
                if (writer >= 0) begin
                    if (dv[writer] && drdy) begin
                        ed.port = 1'(writer);
                        ed.bits = cur[writer].data[beats];
                        ed.mask = cur[writer].mask[beats];
                        dat_q.push_back(ed);
                        beats++;
                        if (beats == NB) begin
                            has_txn[writer] = 1'b0;
                            in_data[writer] = 1'b0;
                            writer = -1;
                        end
                    end
                end else begin
                    w = -1;
                    if (held >= 0) w = held;
                    else if (rv == 2'b11) w = rr_last ? 0 : 1;
                    else if (rv[0]) w = 0;
                    else if (rv[1]) w = 1;
                    if (w >= 0) begin
                        if (mrdy) begin
                            er.port = 1'(w);
                            er.rw   = cur[w].rw;
                            er.addr = cur[w].addr;
                            er.tag  = {1'(w), cur[w].tag};
                            req_q.push_back(er);
                            rr_last = 1'(w);
                            held = -1;
                            if (cur[w].rw) begin
                                writer = w;
                                beats = 0;
                                in_data[w] = 1'b1;
                            end else begin
                                has_txn[w] = 1'b0;
                            end
                        end else begin
                            held = w;
                        end
                    end
                end
            end
        end
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : monitor
        req_exp_t er;
        dat_exp_t ed;
        rsp_exp_t es;
        logic [7:0] flags;
        forever begin
            @(negedge clk);
            if (!reset) begin
                flags = {mem_bus.req_valid, mem_bus.req_data_valid, ic_bus.req_ready, dc_bus.req_ready,
                         ic_bus.req_data_ready, dc_bus.req_data_ready, ic_bus.resp_valid, dc_bus.resp_valid};
                checks++;
                if (flags != 8'h00) begin
                    errors++;
                    $display("FAIL reset_outputs: got %b, required 00000000", flags);
                end
            end else begin
                checks++;
                if (mem_bus.req_valid && mem_bus.req_data_valid) begin
                    errors++;
                    $display("FAIL req_data_overlap: got req_valid=1 data_valid=1, required not both");
                end
                if (mem_bus.req_valid && mem_bus.req_ready) begin
                    checks++;
                    if (req_q.size() == 0) begin
                        errors++;
                        $display("FAIL request: got tag=%h addr=%h with none expected", mem_bus.req_tag, mem_bus.req_addr);
                    end else begin
                        er = req_q.pop_front();
                        if ({dc_bus.req_ready, ic_bus.req_ready, mem_bus.req_rw, mem_bus.req_addr, mem_bus.req_tag} !=
                            {er.port, ~er.port, er.rw, er.addr, er.tag}) begin
                            errors++;
                            $display("FAIL request: got rdy(dc,ic)=%b%b rw=%b addr=%h tag=%h, required rdy=%b%b rw=%b addr=%h tag=%h",
                                     dc_bus.req_ready, ic_bus.req_ready, mem_bus.req_rw, mem_bus.req_addr, mem_bus.req_tag,
                                     er.port, ~er.port, er.rw, er.addr, er.tag);
                        end
                    end
                end
                if (mem_bus.req_data_valid && mem_bus.req_data_ready) begin
                    checks++;
                    if (dat_q.size() == 0) begin
                        errors++;
                        $display("FAIL data_beat: got bits=%h with none expected", mem_bus.req_data_bits);
                    end else begin
                        ed = dat_q.pop_front();
                        if ({dc_bus.req_data_ready, ic_bus.req_data_ready, mem_bus.req_data_bits, mem_bus.req_data_mask} !=
                            {ed.port, ~ed.port, ed.bits, ed.mask}) begin
                            errors++;
                            $display("FAIL data_beat: got rdy(dc,ic)=%b%b bits=%h mask=%h, required rdy=%b%b bits=%h mask=%h",
                                     dc_bus.req_data_ready, ic_bus.req_data_ready, mem_bus.req_data_bits, mem_bus.req_data_mask,
                                     ed.port, ~ed.port, ed.bits, ed.mask);
                        end
                    end
                end
                if (ic_bus.resp_valid || dc_bus.resp_valid) begin
                    checks++;
                    if (rsp_q.size() == 0) begin
                        errors++;
                        $display("FAIL response: got valid(dc,ic)=%b%b with none expected", dc_bus.resp_valid, ic_bus.resp_valid);
                    end else begin
                        es = rsp_q.pop_front();
                        if ({dc_bus.resp_valid, ic_bus.resp_valid, ic_bus.resp_tag, dc_bus.resp_tag, ic_bus.resp_data, dc_bus.resp_data} !=
                            {es.port, ~es.port, es.tag, es.tag, es.data, es.data}) begin
                            errors++;
                            $display("FAIL response: got valid(dc,ic)=%b%b tag(ic,dc)=%h,%h data=%h, required valid=%b%b tag=%h data=%h",
                                     dc_bus.resp_valid, ic_bus.resp_valid, ic_bus.resp_tag, dc_bus.resp_tag, ic_bus.resp_data,
                                     es.port, ~es.port, es.tag, es.data);
                        end
                    end
                end
                checks++;
                if (req_q.size() + dat_q.size() + rsp_q.size() != 0) begin
                    errors++;
                    $display("FAIL missed_event: got pending req=%0d data=%0d resp=%0d, required 0 0 0",
                             req_q.size(), dat_q.size(), rsp_q.size());
                    req_q.delete();
                    dat_q.delete();
                    rsp_q.delete();
                end
            end
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single external memory port (request, write-data and response channels) between the instruction cache (port 0, `ic_`) and the data cache (port 1, `dc_`). It sits inside `riscv_top`, between the two caches and the top-level `mem_*` pins. It grants requests round-robin and locks the write-data channel to the writer for a full line. It routes responses back using a requester-ID bit carried in the tag MSB.

## Interface
- MEM_ADDR_BITS, 28, line address width
- MEM_DATA_BITS, 128, data beat width
- MEM_TAG_BITS, 5, external tag width; each cache port uses MEM_TAG_BITS-1
- DATA_BEATS, 4, write-data beats per line

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- {ic,dc}_req_valid  in  1  request valid
- {ic,dc}_req_ready  out  1  request accepted
- {ic,dc}_req_rw  in  1  1 = write
- {ic,dc}_req_addr  in  MEM_ADDR_BITS  line address
- {ic,dc}_req_tag  in  MEM_TAG_BITS-1  requester tag
- {ic,dc}_req_data_valid  in  1  write beat valid
- {ic,dc}_req_data_ready  out  1  write beat accepted
- {ic,dc}_req_data_bits  in  MEM_DATA_BITS  write beat
- {ic,dc}_req_data_mask  in  MEM_DATA_BITS/8  byte mask
- {ic,dc}_resp_valid  out  1  response beat for this port
- {ic,dc}_resp_tag  out  MEM_TAG_BITS-1  tag low bits
- {ic,dc}_resp_data  out  MEM_DATA_BITS  response beat (broadcast)
- mem_req_valid/ready/rw/addr/tag  out/in/out/out/out  1/1/1/MEM_ADDR_BITS/MEM_TAG_BITS  external request channel
- mem_req_data_valid/ready/bits/mask  out/in/out/out  1/1/MEM_DATA_BITS/MEM_DATA_BITS/8  external write-data channel
- mem_resp_valid/tag/data  in  1/MEM_TAG_BITS/MEM_DATA_BITS  external response channel

## Operation
- State register: IDLE, HOLD, WDATA. Registers: owner (1b), rr_last (1b), beat_cnt (log2 DATA_BEATS).
- IDLE:
  - Grant is combinational. If only one port is valid, that port wins. If both are valid, the port != rr_last wins.
  - The winner's rw/addr drive the mem request; mem_req_tag = {winner_id, winner_tag}; mem_req_valid = 1.
  - The winner's req_ready = mem_req_ready. The loser's req_ready = 0.
- On a request handshake (valid && ready, from IDLE or HOLD):
  - rr_last <= granted id.
  - If rw = 1: owner <= id, beat_cnt <= 0, next state WDATA. Otherwise next state IDLE.
- Granted but mem_req_ready = 0 in IDLE: owner <= winner, next state HOLD.
- HOLD:
  - Only the owner is forwarded. The other port's req_ready = 0.
  - The grant cannot change until the handshake completes. Requester valid/addr stability is the requester's obligation.
- WDATA:
  - mem_req_valid = 0 and both req_ready = 0.
  - Data channel connected to owner: mem_req_data_valid = owner data_valid; owner data_ready = mem_req_data_ready.
  - beat_cnt increments on each data handshake. The handshake with beat_cnt = DATA_BEATS-1 returns to IDLE.
- Outside WDATA: mem_req_data_valid = 0 and both data_ready = 0.
- Responses:
  - port k resp_valid = mem_resp_valid && mem_resp_tag[MSB] == k.
  - resp_tag = mem_resp_tag[MSB-1:0]; resp_data = mem_resp_data to both ports.
  - No backpressure; responses are independent of arbiter state, including during WDATA.
- Reset (reset == 0 at posedge): state IDLE, owner 0, rr_last 1 (port 0 wins the first tie), beat_cnt 0.
  - While reset is low, all valid/ready outputs are forced to 0.
  - Reset mid-HOLD or mid-WDATA abandons the transaction. Cleanup of a partial line is the memory side's responsibility.

## Timing
- Zero-cycle combinational paths: requester valid to mem_req_valid, and mem_req_ready to requester ready. No pipeline registers.
- A read handshake in cycle N allows a new grant in cycle N+1. Back-to-back reads from alternating ports are accepted every cycle.
- A write occupies the request channel for 1 handshake plus DATA_BEATS data handshakes. The next request is grantable in the cycle after the last beat.
- The arbiter never presents a request and a data beat in the same cycle.
- Outputs are functions of state and inputs; no extra output registers.

## Test plan
- Single icache read: ic valid, addr 0x0000010, tag 0x3, mem ready = 1 → same-cycle mem_req_valid, mem_req_tag = 0x03. Response with tag 0x03, 4 beats → ic_resp_valid for 4 cycles, tag 0x3; dc_resp_valid stays 0.
- Tie after reset: both ports read, ready = 1 → cycle 0 grants ic (mem tag 0x0X), cycle 1 grants dc (mem tag 0x1X), then alternation continues.
- Stall lock: ic wins with mem_req_ready = 0 for 3 cycles while dc is valid → state HOLD, mem_req_addr = ic addr throughout, dc_req_ready = 0. Ready rises → ic handshake; dc granted next cycle.
- dc write: rw = 1, 4 beats, mem_req_data_ready pattern 1,0,1,1,0,1 → exactly 4 data handshakes with mask/data passed through; ic_req_ready = 0 throughout. Return to IDLE after beat 4; ic granted the following cycle.
- Reset mid-WDATA after 2 beats: reset low one cycle → next cycle IDLE, beat_cnt 0, all valids/readies 0 during reset. A fresh dc write completes all 4 beats.
- Response routing during WDATA: mem_resp_valid with tag 0x12 while dc is writing → dc_resp_valid = 1, dc_resp_tag = 0x2, ic_resp_valid = 0, write beats unaffected.
